// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: grants one requester at a time and holds it for up to weight transactions.
// Define WRR_WEIGHT_EN for per-user budgets; otherwise each grant covers a single transaction.
module weighted_rr_arbiter #(
  parameter int USER      = 4,
  parameter int USER_LOG2 = $clog2(USER),
  parameter int WEIGHT_W  = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [USER-1:0]            request,
  input  logic [USER*WEIGHT_W-1:0]   weight,
  input  logic                       ack,
  input  logic                       last,
  output logic [USER-1:0]            grant,
  output logic                       grant_valid,
  output logic [USER_LOG2-1:0]       grant_id,
  output logic [WEIGHT_W-1:0]        credit
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic [USER-1:0]       grant_q, grant_d;
  logic [USER_LOG2-1:0]  grant_id_q, grant_id_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;
  logic [USER_LOG2-1:0]  ptr_q, ptr_d;
  logic                  busy_q, busy_d;

  logic [USER_LOG2:0]    pick_idle, pick_rel, pick_sel;
  logic [USER_LOG2-1:0]  ptr_rel, new_id;
  logic [WEIGHT_W-1:0]   new_credit;
  logic                  keep_grant;
  logic                  release_now;

  // First set bit of req at or above start, wrapping modulo USER; MSB flags a hit.
  function automatic logic [USER_LOG2:0] pick_next(input logic [USER-1:0] req,
                                                   input logic [USER_LOG2-1:0] start);
    logic [USER_LOG2:0]   res;
    logic [USER_LOG2-1:0] id_l;
    int unsigned          idx;
    res = '0;
    for (int unsigned i = 0; i < USER; i++) begin
      idx = 32'(start) + i;
      if (idx >= USER) idx = idx - USER;
      id_l = idx[USER_LOG2-1:0];
      if (!res[USER_LOG2] && req[id_l]) res = {1'b1, id_l};
    end
    return res;
  endfunction

  assign ptr_rel   = (grant_id_q == USER_LOG2'(USER - 1)) ? '0 : grant_id_q + 1'b1;
  assign pick_idle = pick_next(request, ptr_q);
  assign pick_rel  = pick_next(request & ~grant_q, ptr_rel);
  assign pick_sel  = (state_q == S_IDLE) ? pick_idle : pick_rel;
  assign new_id    = pick_sel[USER_LOG2-1:0];

`ifdef WRR_WEIGHT_EN
  logic [WEIGHT_W-1:0] weight_a [USER];
  always_comb begin
    for (int unsigned g = 0; g < USER; g++) weight_a[g] = weight[g*WEIGHT_W +: WEIGHT_W];
  end
  assign new_credit = (weight_a[new_id] == '0) ? WEIGHT_W'(1) : weight_a[new_id];
  assign keep_grant = (credit_q > WEIGHT_W'(1)) && request[grant_id_q];
`else
  logic unused_weight;
  assign unused_weight = ^weight;
  assign new_credit    = WEIGHT_W'(1);
  assign keep_grant    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    credit_d    = credit_q;
    ptr_d       = ptr_q;
    busy_d      = busy_q;
    release_now = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_idle[USER_LOG2]) begin
          state_d          = S_HOLD;
          grant_d          = '0;
          grant_d[new_id]  = 1'b1;
          grant_id_d       = new_id;
          credit_d         = new_credit;
          busy_d           = 1'b0;
        end
      end
      S_HOLD: begin
        if (ack && last) begin
          busy_d = 1'b0;
          if (keep_grant) credit_d = credit_q - WEIGHT_W'(1);
          else            release_now = 1'b1;
        end else if (ack) begin
          busy_d = 1'b1;
        end else if (!busy_q && !request[grant_id_q]) begin
          release_now = 1'b1;
        end
        // Release re-arbitrates from the advanced pointer in the same cycle, skipping the old holder.
        if (release_now) begin
          ptr_d  = ptr_rel;
          busy_d = 1'b0;
          if (pick_rel[USER_LOG2]) begin
            grant_d         = '0;
            grant_d[new_id] = 1'b1;
            grant_id_d      = new_id;
            credit_d        = new_credit;
          end else begin
            state_d    = S_IDLE;
            grant_d    = '0;
            grant_id_d = '0;
            credit_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      credit_q   <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      credit_q   <= credit_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = grant_id_q;
  assign credit      = credit_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed bench for weighted_rr_arbiter: a USER=4 instance for the main scenarios and a USER=3 instance for wrap order.
// Expected credit values follow WRR_WEIGHT_EN as defined for the build.
module tb_weighted_rr_arbiter;

`ifdef WRR_WEIGHT_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic        CLK;
  logic        RST;

  logic [3:0]  req;
  logic [15:0] wt;
  logic        ack, lst;
  logic [3:0]  g4;
  logic        gv4;
  logic [1:0]  gid4;
  logic [3:0]  cr4;

  logic [2:0]  req3;
  logic [11:0] wt3;
  logic        ack3, lst3;
  logic [2:0]  g3;
  logic        gv3;
  logic [1:0]  gid3;
  logic [3:0]  cr3;

  int n_assert = 0;
  int n_fail   = 0;

  weighted_rr_arbiter #(.USER(4), .WEIGHT_W(4)) u4 (
    .CLK(CLK), .RST(RST), .request(req), .weight(wt), .ack(ack), .last(lst),
    .grant(g4), .grant_valid(gv4), .grant_id(gid4), .credit(cr4)
  );

  weighted_rr_arbiter #(.USER(3), .WEIGHT_W(4)) u3 (
    .CLK(CLK), .RST(RST), .request(req3), .weight(wt3), .ack(ack3), .last(lst3),
    .grant(g3), .grant_valid(gv3), .grant_id(gid3), .credit(cr3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic c4(input string tag, input logic [3:0] eg, input logic [1:0] eid, input int ecr);
    chk({tag, ".grant"},  32'(g4),   32'(eg));
    chk({tag, ".valid"},  32'(gv4),  32'(eg != 4'b0));
    chk({tag, ".id"},     32'(gid4), 32'(eid));
    chk({tag, ".credit"}, 32'(cr4),  32'(ecr));
  endtask

  task automatic c3(input string tag, input logic [2:0] eg, input logic [1:0] eid, input int ecr);
    chk({tag, ".grant"},  32'(g3),   32'(eg));
    chk({tag, ".valid"},  32'(gv3),  32'(eg != 3'b0));
    chk({tag, ".id"},     32'(gid3), 32'(eid));
    chk({tag, ".credit"}, 32'(cr3),  32'(ecr));
  endtask

  initial begin
    RST = 1'b1; req = '0; wt = '0; ack = 1'b0; lst = 1'b0;
    req3 = '0; wt3 = '0; ack3 = 1'b0; lst3 = 1'b0;
    #1;
    c4("rst", 4'b0000, 2'd0, 0);
    c3("rst3", 3'b000, 2'd0, 0);
    tick(); tick();
    RST = 1'b0;

    // first grant from ptr 0, then back-to-back handoff
    wt = 16'h1111; req = 4'b1010;
    tick(); c4("t1_first", 4'b0010, 2'd1, 1);
    ack = 1'b1; lst = 1'b1;
    tick(); c4("t1_next", 4'b1000, 2'd3, 1);
    ack = 1'b0; lst = 1'b0; req = 4'b0000;
    tick(); c4("t1_idle", 4'b0000, 2'd0, 0);

    // weight 3 on user 0 with ack&last every cycle
    wt = 16'h1113; req = 4'b0001;
    tick(); c4("t2_e1", 4'b0001, 2'd0, WEN ? 3 : 1);
    ack = 1'b1; lst = 1'b1;
    tick(); c4("t2_e2", WEN ? 4'b0001 : 4'b0000, 2'd0, WEN ? 2 : 0);
    tick(); c4("t2_e3", 4'b0001, 2'd0, 1);
    tick(); c4("t2_e4", 4'b0000, 2'd0, 0);
    ack = 1'b0; lst = 1'b0; req = 4'b0011;
    tick(); c4("t2_ptr", 4'b0010, 2'd1, 1);

    // busy holder ignores its own request drop
    req = 4'b0000;
    tick(); c4("t3_drop", 4'b0000, 2'd0, 0);
    wt = 16'h1213; req = 4'b0100;
    tick(); c4("t3_grant", 4'b0100, 2'd2, WEN ? 2 : 1);
    ack = 1'b1; lst = 1'b0;
    tick(); c4("t3_beat", 4'b0100, 2'd2, WEN ? 2 : 1);
    ack = 1'b0; req = 4'b0000;
    tick(); c4("t3_busy1", 4'b0100, 2'd2, WEN ? 2 : 1);
    tick(); c4("t3_busy2", 4'b0100, 2'd2, WEN ? 2 : 1);
    ack = 1'b1; lst = 1'b1;
    tick(); c4("t3_rel", 4'b0000, 2'd0, 0);
    ack = 1'b0; lst = 1'b0;

    // holder 1 drops before any ack: ptr moves to 2
    req = 4'b0010;
    tick(); c4("t4_grant", 4'b0010, 2'd1, 1);
    req = 4'b1101;
    tick(); c4("t4_next", 4'b0100, 2'd2, WEN ? 2 : 1);

    // asynchronous reset mid-hold, then arbitration restarts at ptr 0
    #2 RST = 1'b1;
    #1 c4("t5_rst", 4'b0000, 2'd0, 0);
    tick();
    RST = 1'b0;
    wt = 16'h1215; req = 4'b1111;
    tick(); c4("t5_first", 4'b0001, 2'd0, WEN ? 5 : 1);
    ack = 1'b1; lst = 1'b1;
    tick(); c4("t5_ack", WEN ? 4'b0001 : 4'b0010, WEN ? 2'd0 : 2'd1, WEN ? 4 : 1);
    ack = 1'b0; lst = 1'b0; req = 4'b0000;
    tick(); c4("t5_drop", 4'b0000, 2'd0, 0);

    // zero weight loads 1; weight changes during hold are ignored
    wt = 16'h0215; req = 4'b1000;
    tick(); c4("t6_w0", 4'b1000, 2'd3, 1);
    wt = 16'h7215;
    tick(); c4("t6_hold", 4'b1000, 2'd3, 1);
    ack = 1'b1; lst = 1'b1;
    tick(); c4("t6_rel", 4'b0000, 2'd0, 0);
    ack = 1'b0; lst = 1'b0; req = 4'b0000;

    // USER=3 wrap order 0,1,2,0
    wt3 = 12'h111; req3 = 3'b111; ack3 = 1'b1; lst3 = 1'b1;
    tick(); c3("u3_a", 3'b001, 2'd0, 1);
    tick(); c3("u3_b", 3'b010, 2'd1, 1);
    tick(); c3("u3_c", 3'b100, 2'd2, 1);
    tick(); c3("u3_d", 3'b001, 2'd0, 1);
    req3 = '0; ack3 = 1'b0; lst3 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
